// File: rtl/pipeline_mem_stage_pkg.sv
// Shared definitions for the memory-access stage: RV64 load/store funct3
// codes, the access FSM encoding and the write-back source select codes.
package pipeline_mem_stage_pkg;

   // Load funct3 encodings; bits [1:0] give the size, bit 2 marks zero-extension
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   // Size field values (funct3[1:0])
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_DBL  = 2'b11;

   // Write-back source select
   localparam logic [1:0] WB_NONE = 2'b00;
   localparam logic [1:0] WB_PC4  = 2'b01;
   localparam logic [1:0] WB_ALU  = 2'b10;
   localparam logic [1:0] WB_MEM  = 2'b11;

   // Data-memory access FSM
   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_RESP = 1'b1
   } mem_state_t;

   // Unshifted byte strobe for an access of the given size
   function automatic logic [7:0] size_strobe(input logic [1:0] size);
      logic [7:0] strb;
      case (size)
         SZ_BYTE: strb = 8'h01;
         SZ_HALF: strb = 8'h03;
         SZ_WORD: strb = 8'h0F;
         default: strb = 8'hFF;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/pipeline_mem_stage_align.sv
// Byte-lane steering for the data-memory port: places store data and strobes
// on the correct lanes of the 64-bit bus, extracts and extends load data,
// and flags accesses that are not naturally aligned for their size.
module mem_align_unit
   import pipeline_mem_stage_pkg::*;
(
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [63:0] store_data,
   input  logic [63:0] load_raw,
   output logic        misalign,
   output logic [63:0] store_lanes,
   output logic [7:0]  store_strb,
   output logic [63:0] load_data
);

   logic [5:0]  shamt;
   logic [63:0] load_shift;

   assign shamt = {offset, 3'b000};

   // Alignment check, store lane/strobe placement and load extract/extend
   always_comb begin
      case (funct3[1:0])
         SZ_BYTE: misalign = 1'b0;
         SZ_HALF: misalign = offset[0];
         SZ_WORD: misalign = |offset[1:0];
         default: misalign = |offset;
      endcase

      store_lanes = store_data << shamt;
      store_strb  = size_strobe(funct3[1:0]) << offset;

      load_shift = load_raw >> shamt;
      case (funct3)
         F3_LB:   load_data = {{56{load_shift[7]}},  load_shift[7:0]};
         F3_LH:   load_data = {{48{load_shift[15]}}, load_shift[15:0]};
         F3_LW:   load_data = {{32{load_shift[31]}}, load_shift[31:0]};
         F3_LBU:  load_data = {56'd0, load_shift[7:0]};
         F3_LHU:  load_data = {48'd0, load_shift[15:0]};
         F3_LWU:  load_data = {32'd0, load_shift[31:0]};
         default: load_data = load_shift;
      endcase
   end

endmodule

// File: rtl/pipeline_mem_stage.sv
// Memory-access stage of the RV64 pipeline. Holds the EX/MEM slot, runs a
// request/response data-memory access for loads and stores, stalls EX while
// the access is outstanding, and emits a registered write-back bundle on the
// edge where the slot completes. A watchdog turns a stuck access into a bus
// error so the pipeline cannot hang.
module pipeline_mem_stage
   import pipeline_mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_EX,
   input  logic [63:0] alu_result_EX,
   input  logic [63:0] rs2_data_EX,
   input  logic [4:0]  rd_EX,
   input  logic        reg_write_EX,
   input  logic [1:0]  rf_wr_sel_EX,
   input  logic [63:0] pc_EX,
   input  logic        mem_read_EX,
   input  logic        mem_write_EX,
   input  logic [2:0]  funct3_EX,
   output logic        stall_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [63:0] dmem_addr,
   output logic [63:0] dmem_wdata,
   output logic [7:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic        dmem_rvalid,
   input  logic [63:0] dmem_rdata,
   output logic [63:0] alu_result_MEM,
   output logic [63:0] mem_data_MEM,
   output logic [63:0] pc_MEM,
   output logic [4:0]  rd_MEM,
   output logic        reg_write_MEM,
   output logic [1:0]  rf_wr_sel_MEM,
   output logic        misalign_MEM,
   output logic        bus_err_MEM
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   // Slot control (reset) and slot payload (no reset)
   logic        slot_valid_p0;
   logic        slot_ld_p0;
   logic        slot_st_p0;
   logic [63:0] slot_addr_p0;
   logic [63:0] slot_wdata_p0;
   logic [63:0] slot_pc_p0;
   logic [4:0]  slot_rd_p0;
   logic        slot_rw_p0;
   logic [1:0]  slot_sel_p0;
   logic [2:0]  slot_f3_p0;

   mem_state_t  state;
   mem_state_t  state_next;
   logic [7:0]  wait_cnt;

   logic        misalign;
   logic        mem_op;
   logic        access;
   logic        timeout;
   logic        complete;
   logic        timeout_fault;
   logic        capture;
   logic [63:0] store_lanes;
   logic [7:0]  store_strb;
   logic [63:0] load_data;

   mem_align_unit u_align (
      .offset      (slot_addr_p0[2:0]),
      .funct3      (slot_f3_p0),
      .store_data  (slot_wdata_p0),
      .load_raw    (dmem_rdata),
      .misalign    (misalign),
      .store_lanes (store_lanes),
      .store_strb  (store_strb),
      .load_data   (load_data)
   );

   assign mem_op     = slot_valid_p0 & (slot_ld_p0 | slot_st_p0);
   assign access     = mem_op & ~misalign;
   assign timeout    = access & (wait_cnt == TIMEOUT_LIMIT);
   assign stall_MEM  = slot_valid_p0 & ~complete;
   assign capture    = ~stall_MEM;

   assign dmem_we    = slot_st_p0;
   assign dmem_addr  = {slot_addr_p0[63:3], 3'b000};
   assign dmem_wdata = store_lanes;
   assign dmem_wstrb = store_strb;

   // Access FSM next state, request and slot completion; a handshake or
   // response takes priority over a timeout landing in the same cycle
   always_comb begin
      state_next    = state;
      complete      = 1'b0;
      timeout_fault = 1'b0;
      dmem_req      = 1'b0;
      if (!slot_valid_p0) begin
         state_next = ST_IDLE;
      end else if (!access) begin
         complete = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               dmem_req = 1'b1;
               if (dmem_ready) begin
                  if (slot_ld_p0) state_next = ST_WAIT_RESP;
                  else            complete   = 1'b1;
               end else if (timeout) begin
                  complete      = 1'b1;
                  timeout_fault = 1'b1;
               end
            end
            ST_WAIT_RESP: begin
               if (dmem_rvalid) begin
                  complete   = 1'b1;
                  state_next = ST_IDLE;
               end else if (timeout) begin
                  complete      = 1'b1;
                  timeout_fault = 1'b1;
                  state_next    = ST_IDLE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // EX/MEM slot control: capture when not stalled, a cleared valid is a bubble
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_valid_p0 <= 1'b0;
         slot_ld_p0    <= 1'b0;
         slot_st_p0    <= 1'b0;
      end else if (capture) begin
         slot_valid_p0 <= valid_EX;
         slot_ld_p0    <= mem_read_EX;
         slot_st_p0    <= mem_write_EX & ~mem_read_EX;
      end
   end

   // EX/MEM slot payload, captured alongside the control bits
   always_ff @(posedge clk) begin
      if (capture) begin
         slot_addr_p0  <= alu_result_EX;
         slot_wdata_p0 <= rs2_data_EX;
         slot_pc_p0    <= pc_EX;
         slot_rd_p0    <= rd_EX;
         slot_rw_p0    <= reg_write_EX;
         slot_sel_p0   <= rf_wr_sel_EX;
         slot_f3_p0    <= funct3_EX;
      end
   end

   // FSM state and watchdog counter; the counter restarts on every new slot
   // and on every state change so each phase gets the full wait budget
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_next;
         if (capture || (state_next != state)) wait_cnt <= 8'd0;
         else                                  wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // MEM/WB bundle: loads from the slot on completion, otherwise a bubble
   // that clears the write enable and fault flags and holds everything else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_result_MEM <= 64'd0;
         mem_data_MEM   <= 64'd0;
         pc_MEM         <= 64'd0;
         rd_MEM         <= 5'd0;
         reg_write_MEM  <= 1'b0;
         rf_wr_sel_MEM  <= 2'b00;
         misalign_MEM   <= 1'b0;
         bus_err_MEM    <= 1'b0;
      end else if (complete) begin
         alu_result_MEM <= slot_addr_p0;
         mem_data_MEM   <= load_data;
         pc_MEM         <= slot_pc_p0;
         rd_MEM         <= slot_rd_p0;
         reg_write_MEM  <= slot_rw_p0 & ~(mem_op & misalign) & ~timeout_fault;
         rf_wr_sel_MEM  <= slot_sel_p0;
         misalign_MEM   <= mem_op & misalign;
         bus_err_MEM    <= timeout_fault;
      end else begin
         reg_write_MEM  <= 1'b0;
         misalign_MEM   <= 1'b0;
         bus_err_MEM    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Self-checking bench for pipeline_mem_stage: directed vector table, a
// randomized run against a behavioural model, and hand-written sequences
// for back-to-back issue and reset during an outstanding load.
module tb_pipeline_mem_stage;
   import pipeline_mem_stage_pkg::*;

   localparam int TO = 255;

   logic        clk, reset, valid_EX;
   logic [63:0] alu_result_EX, rs2_data_EX, pc_EX;
   logic [4:0]  rd_EX;
   logic        reg_write_EX, mem_read_EX, mem_write_EX;
   logic [1:0]  rf_wr_sel_EX;
   logic [2:0]  funct3_EX;
   logic        stall_MEM, dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ready, dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic [63:0] alu_result_MEM, mem_data_MEM, pc_MEM;
   logic [4:0]  rd_MEM;
   logic        reg_write_MEM, misalign_MEM, bus_err_MEM;
   logic [1:0]  rf_wr_sel_MEM;

   int checks = 0;
   int failures = 0;

   pipeline_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .valid_EX(valid_EX),
      .alu_result_EX(alu_result_EX), .rs2_data_EX(rs2_data_EX),
      .rd_EX(rd_EX), .reg_write_EX(reg_write_EX), .rf_wr_sel_EX(rf_wr_sel_EX),
      .pc_EX(pc_EX), .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
      .funct3_EX(funct3_EX), .stall_MEM(stall_MEM), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .alu_result_MEM(alu_result_MEM),
      .mem_data_MEM(mem_data_MEM), .pc_MEM(pc_MEM), .rd_MEM(rd_MEM),
      .reg_write_MEM(reg_write_MEM), .rf_wr_sel_MEM(rf_wr_sel_MEM),
      .misalign_MEM(misalign_MEM), .bus_err_MEM(bus_err_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   typedef struct {
      string       nm;
      logic        rd_op, wr_op;
      logic [2:0]  f3;
      logic [63:0] addr, rs2;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  sel;
      int          rdy, rv;
      logic [63:0] rdata;
      int          exp_stall;
      logic [63:0] exp_md, exp_wd;
      logic [7:0]  exp_ws;
      logic        exp_mis, exp_err;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic model_mis(input logic [63:0] addr, input logic [2:0] f3);
      return (addr % nbytes(f3)) != 0;
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] rdata, input int o, input logic [2:0] f3);
      int n;
      logic [63:0] v, mask;
      n = nbytes(f3);
      v = rdata >> (8 * o);
      if (n == 8) return v;
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] model_wstrb(input int o, input logic [2:0] f3);
      logic [15:0] s;
      s = ((16'd1 << nbytes(f3)) - 16'd1) << o;
      return s[7:0];
   endfunction

   // Issue one instruction into an idle stage, play the memory side with the
   // given ready/response delays, then check the emitted bundle
   task automatic run_instr(input vec_t v, input logic [63:0] pc);
      logic is_ld, is_st, is_mem, hs, bad_req, done, exp_hs;
      int cyc, hs_cyc, stalls;
      is_ld  = v.rd_op;
      is_st  = v.wr_op & ~v.rd_op;
      is_mem = (is_ld | is_st) & ~v.exp_mis;
      exp_hs = is_mem && (v.rdy <= v.exp_stall);
      valid_EX = 1'b1; alu_result_EX = v.addr; rs2_data_EX = v.rs2; pc_EX = pc;
      rd_EX = v.rd; reg_write_EX = v.rw; rf_wr_sel_EX = v.sel;
      mem_read_EX = v.rd_op; mem_write_EX = v.wr_op; funct3_EX = v.f3;
      dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      @(posedge clk); #1;
      valid_EX = 1'b0;
      hs = 0; hs_cyc = 0; bad_req = 0; done = 0; cyc = 0; stalls = 0;
      while (!done && cyc < 2000) begin
         dmem_ready  = !hs && (cyc >= v.rdy);
         dmem_rvalid = hs && is_ld && ((cyc - hs_cyc) == v.rv);
         dmem_rdata  = v.rdata;
         #1;
         if (dmem_req && !is_mem) bad_req = 1;
         if (dmem_req && dmem_ready && !hs) begin
            hs = 1; hs_cyc = cyc;
            chk({v.nm, "_addr"}, dmem_addr, v.addr & ~64'd7);
            chk({v.nm, "_we"}, 64'(dmem_we), 64'(is_st));
            if (is_st) begin
               chk({v.nm, "_wdata"}, dmem_wdata, v.exp_wd);
               chk({v.nm, "_wstrb"}, 64'(dmem_wstrb), 64'(v.exp_ws));
            end
         end
         if (stall_MEM) stalls++;
         else done = 1;
         @(posedge clk); #1;
         cyc++;
      end
      dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      chk({v.nm, "_done"}, 64'(done), 64'd1);
      chk({v.nm, "_stall_cycles"}, 64'(stalls), 64'(v.exp_stall));
      chk({v.nm, "_handshake"}, 64'(hs), 64'(exp_hs));
      chk({v.nm, "_no_stray_req"}, 64'(bad_req), 64'd0);
      chk({v.nm, "_rd"}, 64'(rd_MEM), 64'(v.rd));
      chk({v.nm, "_alu"}, alu_result_MEM, v.addr);
      chk({v.nm, "_pc"}, pc_MEM, pc);
      chk({v.nm, "_sel"}, 64'(rf_wr_sel_MEM), 64'(v.sel));
      chk({v.nm, "_reg_write"}, 64'(reg_write_MEM), 64'(v.rw & ~v.exp_mis & ~v.exp_err));
      chk({v.nm, "_misalign"}, 64'(misalign_MEM), 64'(v.exp_mis));
      chk({v.nm, "_bus_err"}, 64'(bus_err_MEM), 64'(v.exp_err));
      if (is_ld && !v.exp_mis && !v.exp_err)
         chk({v.nm, "_mem_data"}, mem_data_MEM, v.exp_md);
      @(posedge clk); #1;
      chk({v.nm, "_bubble_after"}, {reg_write_MEM, misalign_MEM, bus_err_MEM, 56'd0, rd_MEM}, {3'b000, 56'd0, v.rd});
   endtask

   vec_t tbl[19];
   vec_t rv;

   initial begin
      reset = 1'b0; valid_EX = 1'b0; alu_result_EX = '0; rs2_data_EX = '0; pc_EX = '0;
      rd_EX = '0; reg_write_EX = 1'b0; rf_wr_sel_EX = '0; mem_read_EX = 1'b0;
      mem_write_EX = 1'b0; funct3_EX = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
      dmem_rdata = '0;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall_req", {62'd0, stall_MEM, dmem_req}, 64'd0);
      chk("rst_bundle_data", alu_result_MEM | mem_data_MEM | pc_MEM, 64'd0);
      chk("rst_bundle_ctrl", {rd_MEM, reg_write_MEM, rf_wr_sel_MEM, misalign_MEM, bus_err_MEM}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // ---- directed vector table ----
      //          nm        rd wr f3      addr             rs2                    rd  rw sel     rdy   rv    rdata                  stall md                     wd                     ws     mis err
      tbl[0]  = '{"add",    0, 0, 3'd0,   64'h1234,        64'd0,                 5,  1, WB_ALU, 0,    0,    64'd0,                 0,   64'd0,                 64'd0,                 8'h00, 0,  0};
      tbl[1]  = '{"lb",     1, 0, F3_LB,  64'h1003,        64'd0,                 7,  1, WB_MEM, 0,    2,    64'h0000_0000_8000_0000, 2, 64'hFFFF_FFFF_FFFF_FF80, 64'd0,               8'h00, 0,  0};
      tbl[2]  = '{"sh",     0, 1, F3_SH,  64'h2006,        64'hABCD,              0,  0, WB_NONE,0,    0,    64'd0,                 0,   64'd0,                 64'hABCD_0000_0000_0000, 8'hC0, 0, 0};
      tbl[3]  = '{"lw_mis", 1, 0, F3_LW,  64'h3002,        64'd0,                 8,  1, WB_MEM, 0,    1,    64'd0,                 0,   64'd0,                 64'd0,                 8'h00, 1,  0};
      tbl[4]  = '{"ld_to",  1, 0, F3_LD,  64'h4000,        64'd0,                 9,  1, WB_MEM, 1000, 1,    64'd0,                 TO,  64'd0,                 64'd0,                 8'h00, 0,  1};
      tbl[5]  = '{"lbu",    1, 0, F3_LBU, 64'h5001,        64'd0,                 10, 1, WB_MEM, 0,    1,    64'h0000_0000_0000_FF00, 1, 64'h0000_0000_0000_00FF, 64'd0,               8'h00, 0,  0};
      tbl[6]  = '{"lhu",    1, 0, F3_LHU, 64'h5006,        64'd0,                 11, 1, WB_MEM, 0,    1,    64'h8001_0000_0000_0000, 1, 64'h0000_0000_0000_8001, 64'd0,               8'h00, 0,  0};
      tbl[7]  = '{"lh",     1, 0, F3_LH,  64'h5006,        64'd0,                 12, 1, WB_MEM, 1,    1,    64'h8001_0000_0000_0000, 2, 64'hFFFF_FFFF_FFFF_8001, 64'd0,               8'h00, 0,  0};
      tbl[8]  = '{"lwu",    1, 0, F3_LWU, 64'h5004,        64'd0,                 13, 1, WB_MEM, 0,    3,    64'h8765_4321_0000_0000, 3, 64'h0000_0000_8765_4321, 64'd0,               8'h00, 0,  0};
      tbl[9]  = '{"lw",     1, 0, F3_LW,  64'h5004,        64'd0,                 14, 1, WB_MEM, 0,    1,    64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321, 64'd0,               8'h00, 0,  0};
      tbl[10] = '{"ld",     1, 0, F3_LD,  64'h5008,        64'd0,                 15, 1, WB_MEM, 2,    1,    64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF, 64'd0,               8'h00, 0,  0};
      tbl[11] = '{"sb",     0, 1, F3_SB,  64'h6005,        64'h1122_3344_5566_77EE, 0, 0, WB_NONE,0,    0,    64'd0,                 0,   64'd0,                 64'h6677_EE00_0000_0000, 8'h20, 0, 0};
      tbl[12] = '{"sd",     0, 1, F3_SD,  64'h7000,        64'hDEAD_BEEF_CAFE_F00D, 0, 0, WB_NONE,3,    0,    64'd0,                 3,   64'd0,                 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 0};
      tbl[13] = '{"sw_mis", 0, 1, F3_SW,  64'h7003,        64'h55,                0,  0, WB_NONE,0,    0,    64'd0,                 0,   64'd0,                 64'd0,                 8'h00, 1,  0};
      tbl[14] = '{"ld_rw",  1, 1, F3_LD,  64'h7010,        64'h55,                16, 1, WB_MEM, 0,    1,    64'hFEDC_BA98_7654_3210, 1, 64'hFEDC_BA98_7654_3210, 64'd0,               8'h00, 0,  0};
      tbl[15] = '{"ld_wto", 1, 0, F3_LD,  64'h7018,        64'd0,                 17, 1, WB_MEM, 0,    1000, 64'd0,                 TO+1, 64'd0,                64'd0,                 8'h00, 0,  1};
      tbl[16] = '{"ld_mis", 1, 0, F3_LD,  64'h7004,        64'd0,                 18, 1, WB_MEM, 0,    1,    64'd0,                 0,   64'd0,                 64'd0,                 8'h00, 1,  0};
      tbl[17] = '{"lh_mis", 1, 0, F3_LH,  64'h5001,        64'd0,                 19, 1, WB_MEM, 0,    1,    64'd0,                 0,   64'd0,                 64'd0,                 8'h00, 1,  0};
      tbl[18] = '{"jal",    0, 0, 3'd0,   64'h9999,        64'd0,                 1,  1, WB_PC4, 0,    0,    64'd0,                 0,   64'd0,                 64'd0,                 8'h00, 0,  0};
      for (int i = 0; i < 19; i++) run_instr(tbl[i], 64'h8000_0000 + 64'(i * 4));

      // ---- randomized instructions against the model ----
      for (int i = 0; i < 40; i++) begin
         int kind, o;
         kind = $urandom_range(0, 2);
         rv.nm = $sformatf("rnd%0d", i);
         rv.rd_op = (kind == 1);
         rv.wr_op = (kind == 2);
         rv.f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
         rv.addr = {$urandom, $urandom};
         rv.rs2 = {$urandom, $urandom};
         rv.rd = 5'($urandom_range(1, 31));
         rv.rw = (kind != 2);
         rv.sel = (kind == 1) ? WB_MEM : WB_ALU;
         rv.rdy = $urandom_range(0, 3);
         rv.rv = $urandom_range(1, 3);
         rv.rdata = {$urandom, $urandom};
         o = int'(rv.addr % 8);
         rv.exp_mis = (kind != 0) && model_mis(rv.addr, rv.f3);
         rv.exp_err = 1'b0;
         if (kind == 0 || rv.exp_mis) rv.exp_stall = 0;
         else if (kind == 2)          rv.exp_stall = rv.rdy;
         else                         rv.exp_stall = rv.rdy + rv.rv;
         rv.exp_md = model_load(rv.rdata, o, rv.f3);
         rv.exp_wd = rv.rs2 << (8 * o);
         rv.exp_ws = model_wstrb(o, rv.f3);
         run_instr(rv, {$urandom, $urandom});
      end

      // ---- back-to-back ALU ops: second captured as first completes ----
      valid_EX = 1'b1; mem_read_EX = 1'b0; mem_write_EX = 1'b0; reg_write_EX = 1'b1;
      rf_wr_sel_EX = WB_ALU; alu_result_EX = 64'h33; rd_EX = 5'd3;
      @(posedge clk); #1;
      alu_result_EX = 64'h44; rd_EX = 5'd4;
      chk("b2b_no_stall", 64'(stall_MEM), 64'd0);
      @(posedge clk); #1;
      chk("b2b_first", {reg_write_MEM, 51'd0, rd_MEM, alu_result_MEM[7:0]}, {1'b1, 51'd0, 5'd3, 8'h33});
      valid_EX = 1'b0;
      @(posedge clk); #1;
      chk("b2b_second", {reg_write_MEM, 51'd0, rd_MEM, alu_result_MEM[7:0]}, {1'b1, 51'd0, 5'd4, 8'h44});

      // ---- load followed by an ALU op held on EX during the stall ----
      valid_EX = 1'b1; mem_read_EX = 1'b1; funct3_EX = F3_LD; alu_result_EX = 64'hA000;
      rd_EX = 5'd20; rf_wr_sel_EX = WB_MEM;
      @(posedge clk); #1;
      mem_read_EX = 1'b0; alu_result_EX = 64'h77; rd_EX = 5'd21; rf_wr_sel_EX = WB_ALU;
      dmem_ready = 1'b1;
      #1;
      chk("hold_stall_req", {62'd0, stall_MEM, dmem_req}, 64'd3);
      @(posedge clk); #1;
      dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h1357_9BDF_2468_ACE0;
      #1;
      chk("hold_resp_no_stall", 64'(stall_MEM), 64'd0);
      @(posedge clk); #1;
      dmem_rvalid = 1'b0; valid_EX = 1'b0;
      chk("hold_ld_bundle", {59'd0, rd_MEM}, 64'd20);
      chk("hold_ld_data", mem_data_MEM, 64'h1357_9BDF_2468_ACE0);
      @(posedge clk); #1;
      chk("hold_alu_bundle", {reg_write_MEM, 51'd0, rd_MEM, alu_result_MEM[7:0]}, {1'b1, 51'd0, 5'd21, 8'h77});

      // ---- reset while waiting for a response, then a late response ----
      valid_EX = 1'b1; mem_read_EX = 1'b1; funct3_EX = F3_LD; alu_result_EX = 64'hB000;
      rd_EX = 5'd22; reg_write_EX = 1'b1;
      @(posedge clk); #1;
      valid_EX = 1'b0; dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      #1;
      chk("wait_state_stall", {62'd0, stall_MEM, dmem_req}, 64'd2);
      reset = 1'b0;
      #1;
      chk("async_rst_stall_req", {62'd0, stall_MEM, dmem_req}, 64'd0);
      chk("async_rst_bundle", {rd_MEM, reg_write_MEM, rf_wr_sel_MEM, misalign_MEM, bus_err_MEM}, 64'd0);
      chk("async_rst_data", alu_result_MEM | mem_data_MEM | pc_MEM, 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF_0000_FFFF_0000;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      @(posedge clk); #1;
      chk("late_rvalid_ignored", {rd_MEM, reg_write_MEM, rf_wr_sel_MEM, misalign_MEM, bus_err_MEM, stall_MEM, dmem_req}, 64'd0);
      chk("late_rvalid_data", mem_data_MEM | alu_result_MEM, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
